// File: rtl/disp_pkg.sv
// Shared definitions for the display register bank and timing path:
// register offsets, bit positions and the register-space select value.
package disp_pkg;

    // Byte offsets of the registers inside the 4 KiB register window
    localparam logic [11:0] DISPADDR_OFS = 12'h000;
    localparam logic [11:0] DISPCTRL_OFS = 12'h004;
    localparam logic [11:0] DISPINT_OFS  = 12'h008;
    localparam logic [11:0] DISPFIFO_OFS = 12'h00C;
    localparam logic [11:0] FRAMECNT_OFS = 12'h010;

    // Value of addr[15:12] that selects this register space
    localparam logic [3:0] REG_SPACE_SEL = 4'h0;

    // Bit positions inside the registers
    localparam int DISPON_BIT   = 0;
    localparam int IRQ_EN_BIT   = 0;
    localparam int IRQ_ST_BIT   = 1;
    localparam int VBLANK_BIT   = 2;
    localparam int UNDER_ST_BIT = 0;
    localparam int OVER_ST_BIT  = 1;

    // Expand four byte enables into a 32-bit bit mask
    function automatic logic [31:0] byte_mask(input logic [3:0] be);
        logic [31:0] m;
        m = '0;
        for (int i = 0; i < 4; i++) begin
            m[i*8 +: 8] = {8{be[i]}};
        end
        return m;
    endfunction

endpackage

// File: rtl/disp_vsync_sync.sv
// Brings the active-low display VSYNC into the ACLK domain and turns its
// falling edge into a registered single-cycle frame-boundary pulse.
// The chain resets to 1 so leaving reset with VSYNC high gives no edge.
module disp_vsync_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic ACLK,
    input  logic ARST,
    input  logic vsync_n,
    output logic vblank,
    output logic frame_pulse
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   last_q;
    logic                   pulse_q;
    logic                   fall;

    // Multi-flop synchroniser on the asynchronous VSYNC input
    always_ff @(posedge ACLK) begin
        if (ARST) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], vsync_n};
        end
    end

    assign fall = last_q & ~sync_q[SYNC_STAGES-1];

    // Remember the previous synchronised level and register the falling-edge pulse
    always_ff @(posedge ACLK) begin
        if (ARST) begin
            last_q  <= 1'b1;
            pulse_q <= 1'b0;
        end else begin
            last_q  <= sync_q[SYNC_STAGES-1];
            pulse_q <= fall;
        end
    end

    assign vblank      = ~sync_q[SYNC_STAGES-1];
    assign frame_pulse = pulse_q;

endmodule

// File: rtl/disp_regbank.sv
// Display register bank: double-buffered frame-buffer base, display enable,
// VSYNC interrupt, sticky FIFO error flags, frame counter and readback.
module disp_regbank
    import disp_pkg::*;
#(
    parameter int ADDR_W      = 29,
    parameter int ALIGN_LSB   = 0,
    parameter int SYNC_STAGES = 2,
    parameter int FCNT_W      = 16,
    parameter int DISPON_SYNC = 0
) (
    input  logic              ACLK,
    input  logic              ARST,
    input  logic              DSP_VSYNC_X,
    input  logic [15:0]       WRADDR,
    input  logic [3:0]        BYTEEN,
    input  logic              WREN,
    input  logic [31:0]       WDATA,
    input  logic [15:0]       RDADDR,
    input  logic              RDEN,
    output logic [31:0]       RDATA,
    output logic              DISPON,
    output logic [ADDR_W-1:0] DISPADDR,
    output logic              DSP_IRQ,
    input  logic              BUF_UNDER,
    input  logic              BUF_OVER
);

    localparam logic [ADDR_W-1:0] ALIGN_MASK = {ADDR_W{1'b1}} << ALIGN_LSB;

    localparam logic [9:0] IDX_DISPADDR = DISPADDR_OFS[11:2];
    localparam logic [9:0] IDX_DISPCTRL = DISPCTRL_OFS[11:2];
    localparam logic [9:0] IDX_DISPINT  = DISPINT_OFS[11:2];
    localparam logic [9:0] IDX_DISPFIFO = DISPFIFO_OFS[11:2];
    localparam logic [9:0] IDX_FRAMECNT = FRAMECNT_OFS[11:2];

    logic [ADDR_W-1:0] shadow_q;
    logic [ADDR_W-1:0] active_q;
    logic              dispon_wr_q;
    logic              dispon_act_q;
    logic              irq_en_q;
    logic              irq_st_q;
    logic              under_st_q;
    logic              over_st_q;
    logic [FCNT_W-1:0] frame_cnt_q;
    logic [31:0]       rdata_q;

    logic              vblank;
    logic              boundary;

    logic              wr_sel;
    logic              wr_dispaddr;
    logic              wr_dispctrl;
    logic              wr_dispint;
    logic              wr_dispfifo;
    logic [31:0]       wmask;
    logic [31:0]       shadow_ext;
    logic [31:0]       shadow_merge;
    logic [31:0]       fcnt_ext;
    logic [31:0]       rd_word;
    logic              irq_clr;
    logic              under_clr;
    logic              over_clr;
    logic              unused_addr_lsbs;

    disp_vsync_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_vsync_sync (
        .ACLK        (ACLK),
        .ARST        (ARST),
        .vsync_n     (DSP_VSYNC_X),
        .vblank      (vblank),
        .frame_pulse (boundary)
    );

    assign unused_addr_lsbs = ^{WRADDR[1:0], RDADDR[1:0]};

    assign wr_sel      = WREN && (WRADDR[15:12] == REG_SPACE_SEL);
    assign wr_dispaddr = wr_sel && (WRADDR[11:2] == IDX_DISPADDR);
    assign wr_dispctrl = wr_sel && (WRADDR[11:2] == IDX_DISPCTRL);
    assign wr_dispint  = wr_sel && (WRADDR[11:2] == IDX_DISPINT);
    assign wr_dispfifo = wr_sel && (WRADDR[11:2] == IDX_DISPFIFO);
    assign wmask       = byte_mask(BYTEEN);

    assign irq_clr   = wr_dispint  && BYTEEN[0] && WDATA[IRQ_ST_BIT];
    assign under_clr = wr_dispfifo && BYTEEN[0] && WDATA[UNDER_ST_BIT];
    assign over_clr  = wr_dispfifo && BYTEEN[0] && WDATA[OVER_ST_BIT];

    // Widen the shadow and frame counter to bus width and merge byte-enabled write data
    always_comb begin
        shadow_ext                 = '0;
        shadow_ext[ADDR_W-1:0]     = shadow_q;
        fcnt_ext                   = '0;
        fcnt_ext[FCNT_W-1:0]       = frame_cnt_q;
        shadow_merge               = (shadow_ext & ~wmask) | (WDATA & wmask);
    end

    // Shadow and active frame-buffer base; active samples the pre-write shadow at the boundary
    always_ff @(posedge ACLK) begin
        if (ARST) begin
            shadow_q <= '0;
            active_q <= '0;
        end else begin
            if (wr_dispaddr) begin
                shadow_q <= shadow_merge[ADDR_W-1:0] & ALIGN_MASK;
            end
            if (boundary) begin
                active_q <= shadow_q;
            end
        end
    end

    // Display enable: written value plus a copy committed at the frame boundary
    always_ff @(posedge ACLK) begin
        if (ARST) begin
            dispon_wr_q  <= 1'b0;
            dispon_act_q <= 1'b0;
        end else begin
            if (wr_dispctrl && BYTEEN[0]) begin
                dispon_wr_q <= WDATA[DISPON_BIT];
            end
            if (boundary) begin
                dispon_act_q <= dispon_wr_q;
            end
        end
    end

    // Interrupt enable and status; a boundary in the clearing cycle keeps the status set
    always_ff @(posedge ACLK) begin
        if (ARST) begin
            irq_en_q <= 1'b0;
            irq_st_q <= 1'b0;
        end else begin
            if (wr_dispint && BYTEEN[0]) begin
                irq_en_q <= WDATA[IRQ_EN_BIT];
            end
            irq_st_q <= boundary | (irq_st_q & ~irq_clr);
        end
    end

    // Sticky FIFO error flags; an active input wins over a simultaneous clear
    always_ff @(posedge ACLK) begin
        if (ARST) begin
            under_st_q <= 1'b0;
            over_st_q  <= 1'b0;
        end else begin
            under_st_q <= BUF_UNDER | (under_st_q & ~under_clr);
            over_st_q  <= BUF_OVER  | (over_st_q  & ~over_clr);
        end
    end

    // Frame counter advances on each boundary while the display is enabled
    always_ff @(posedge ACLK) begin
        if (ARST) begin
            frame_cnt_q <= '0;
        end else if (boundary && DISPON) begin
            frame_cnt_q <= frame_cnt_q + FCNT_W'(1);
        end
    end

    // Readback multiplexer; anything outside the register window reads as zero
    always_comb begin
        rd_word = '0;
        if (RDADDR[15:12] == REG_SPACE_SEL) begin
            case (RDADDR[11:2])
                IDX_DISPADDR: rd_word = shadow_ext;
                IDX_DISPCTRL: rd_word[DISPON_BIT] = dispon_wr_q;
                IDX_DISPINT: begin
                    rd_word[IRQ_EN_BIT] = irq_en_q;
                    rd_word[IRQ_ST_BIT] = irq_st_q;
                    rd_word[VBLANK_BIT] = vblank;
                end
                IDX_DISPFIFO: begin
                    rd_word[UNDER_ST_BIT] = under_st_q;
                    rd_word[OVER_ST_BIT]  = over_st_q;
                end
                IDX_FRAMECNT: rd_word = fcnt_ext;
                default:      rd_word = '0;
            endcase
        end
    end

    // Registered read data, held between read strobes
    always_ff @(posedge ACLK) begin
        if (ARST) begin
            rdata_q <= '0;
        end else if (RDEN) begin
            rdata_q <= rd_word;
        end
    end

    assign RDATA    = rdata_q;
    assign DISPON   = (DISPON_SYNC != 0) ? dispon_act_q : dispon_wr_q;
    assign DISPADDR = active_q;
    assign DSP_IRQ  = irq_st_q & irq_en_q;

endmodule

// File: doc/disp_regbank.md
# disp_regbank

Parametrised register bank for the display IP, sitting between the AXI-lite register bus adapter and the display timing/FIFO path. It holds:
- a frame-buffer base address with shadow/active double buffering, committed at VSYNC;
- display enable;
- a VSYNC interrupt with enable and status;
- sticky FIFO error flags and a frame counter.

It provides full register readback and synchronises DSP_VSYNC_X into the ACLK domain.

## Interface
Parameters:
- ADDR_W, 29: width of DISPADDR (byte address).
- ALIGN_LSB, 0: number of DISPADDR LSBs forced to zero (burst alignment); 0 ≤ ALIGN_LSB < ADDR_W.
- SYNC_STAGES, 2: flip-flop stages on DSP_VSYNC_X (≥2).
- FCNT_W, 16: frame counter width (≤32).
- DISPON_SYNC, 0: 0 = DISPON updates on write; 1 = DISPON commits at next frame boundary.

Ports:
- Reset is ARST, synchronous, active-high. Clock is ACLK.
- ACLK  in  1  system clock
- ARST  in  1  synchronous active-high reset
- DSP_VSYNC_X  in  1  display VSYNC, active low, asynchronous to ACLK
- WRADDR  in  16  write byte address
- BYTEEN  in  4  write byte enables
- WREN  in  1  write strobe, one cycle per write
- WDATA  in  32  write data
- RDADDR  in  16  read byte address
- RDEN  in  1  read strobe
- RDATA  out  32  read data, registered
- DISPON  out  1  display enable
- DISPADDR  out  ADDR_W  active frame-buffer base
- DSP_IRQ  out  1  level interrupt = IRQ_ST & IRQ_EN
- BUF_UNDER  in  1  FIFO underflow, ACLK domain, level/pulse
- BUF_OVER  in  1  FIFO overflow, ACLK domain, level/pulse

## Operation
- Decode: a register is selected only when addr[15:12]==0. Word index is addr[11:2]. Writes honour BYTEEN per byte.
- 0x000 DISPADDR (RW):
  - Writes go to the shadow register, bits [ADDR_W-1:0].
  - Bits below ALIGN_LSB always read and drive 0.
  - Readback returns the shadow value. Upper bits read 0.
- 0x004 DISPCTRL (RW): bit0 DISPON.
  - Readback returns the written value (pending value when DISPON_SYNC=1).
- 0x008 DISPINT:
  - bit0 IRQ_EN (RW).
  - bit1 IRQ_ST (W1C; set at every frame boundary).
  - bit2 VBLANK (RO, synchronised ~DSP_VSYNC_X).
- 0x00C DISPFIFO: bit0 UNDER_ST, bit1 OVER_ST.
  - Each bit is sticky and set while the corresponding input is high. Write-1-to-clear.
- 0x010 FRAMECNT (RO): counts frame boundaries while DISPON=1. Wraps 2^FCNT_W−1 → 0. Writes are ignored.
- Unmapped addresses: writes are ignored, reads return 0.
- Frame boundary = falling edge of synchronised VSYNC, a single-cycle internal pulse. At the boundary:
  - active DISPADDR ← shadow;
  - DISPON ← pending (DISPON_SYNC=1);
  - IRQ_ST ← 1;
  - FRAMECNT++ if DISPON.
- Simultaneous events:
  - A status set and a W1C in the same cycle → the bit stays 1 (set wins).
  - A shadow write in the boundary cycle → active takes the pre-write shadow value; the new value commits at the following boundary.
  - A DISPON write in the boundary cycle with DISPON_SYNC=1 → the same rule applies.
- Reset values:
  - DISPON=0, DISPADDR=0, shadow=0, IRQ_EN=0, IRQ_ST=0, sticky flags=0, FRAMECNT=0, RDATA=0, DSP_IRQ=0.
  - The sync chain resets to 1, so reset does not produce a spurious edge.
- Reset asserted mid-frame clears all state. The first boundary after reset release requires a genuine 1→0 VSYNC transition.

## Timing
- Write effect: the register updates at the ACLK edge sampling WREN. DSP_IRQ and DISPON (DISPON_SYNC=0) change in the same cycle as that register update.
- Read: RDATA is valid on the edge after the RDEN cycle (1-cycle latency). RDATA holds its value when RDEN=0.
- A read in the same cycle as a write to the same address returns the pre-write value.
- VSYNC latency: the boundary pulse occurs SYNC_STAGES+1 edges after the first edge sampling DSP_VSYNC_X low. Boundary outputs are visible one edge later.
- BUF_* set the sticky bit on the edge after they are sampled high. A single-cycle pulse is sufficient.

## Structure
- Shared package disp_pkg holds:
  - register offset constants (DISPADDR_OFS, DISPCTRL_OFS, DISPINT_OFS, DISPFIFO_OFS, FRAMECNT_OFS);
  - bit-position constants;
  - the register-space select value 4'h0.
- Sub-module disp_vsync_sync (parametrised SYNC_STAGES) contains the synchroniser chain and the falling-edge pulse, reusable by the timing block.
- Everything else stays flat in disp_regbank.

## Test plan
- Reset then read all offsets → RDATA=0 everywhere. DSP_IRQ=0 and DISPON=0.
- Write DISPADDR=0x1234_5678, BYTEEN=4'hF, ALIGN_LSB=7:
  - readback 0x1234_5600;
  - DISPADDR output stays 0 until the VSYNC fall, then 0x1234_5600 after SYNC_STAGES+2 edges.
- Write DISPADDR in the exact boundary cycle → active keeps the old shadow; the new value appears at the next VSYNC.
- IRQ_EN=1, VSYNC fall → DSP_IRQ=1.
  - W1C 0x2 → DSP_IRQ=0 next cycle.
  - W1C coincident with the boundary → DSP_IRQ stays 1.
- Pulse BUF_OVER for 1 cycle → DISPFIFO reads 0x2.
  - Write 0x1 → still 0x2.
  - Write 0x2 → reads 0.
- DISPON=1, FCNT_W=4, 17 VSYNC frames → FRAMECNT=1 (wrap).
  - DISPON=0 plus a further frame → the count is unchanged.
